cache_block_memory: RTL and testbench
=====================================

# cache_block_memory

Parametrised data array for the L1 cache, organised as multi-word blocks. It serves single-word CPU accesses with byte enables and a registered read. Two burst engines move whole blocks: a refill path that writes a block from the memory side, and a write-back drain path that streams a dirty block out. It sits under the cache controller, beside the tag/valid/dirty store, and the controller drives all three paths.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8
- IDX_W, 5, set index width; 2**IDX_W blocks
- WORDS_W, 2, word-offset width; WORDS = 2**WORDS_W words per block

Ports:
- iCLK  in  1  clock; all state updates on the rising edge
- iRST  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access strobe
- cpu_we  in  1  1 = write, 0 = read
- cpu_be  in  DATA_W/8  byte enables for writes
- cpu_idx  in  IDX_W  block index
- cpu_off  in  WORDS_W  word within block
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, registered
- cpu_rvalid  out  1  cpu_rdata is valid this cycle
- fill_start  in  1  begin refill of block fill_idx
- fill_idx  in  IDX_W  refill target, sampled on fill_start
- fill_valid  in  1  fill_data word is present
- fill_data  in  DATA_W  refill word; words arrive in order 0..WORDS-1
- fill_ready  out  1  array accepts a refill word
- drain_start  in  1  begin write-back of block drain_idx
- drain_idx  in  IDX_W  drain source, sampled on drain_start
- drain_valid  out  1  drain_data is valid
- drain_data  out  DATA_W  drained word, registered
- drain_last  out  1  the current drain word is word WORDS-1
- drain_ready  in  1  downstream accepts a drain word
- busy  out  1  burst in progress (state != IDLE)
- done  out  1  one-cycle pulse when a burst completes

## Operation
- FSM states: IDLE, FILL, DRAIN. Reset puts the FSM in IDLE, clears the word counter and latched index, and drives every output to 0 (cpu_rdata, drain_data = 0). Array contents are not reset.
- IDLE, cpu_req & cpu_we: for each byte with cpu_be[b] = 1, write cpu_wdata byte b into word {cpu_idx,cpu_off}. Other bytes are unchanged. cpu_be = 0 writes nothing.
- IDLE, cpu_req & !cpu_we: the word is read. cpu_rdata and cpu_rvalid are set on the next edge.
- IDLE, drain_start: latch drain_idx, count = 0, issue a read of word 0, go to DRAIN. drain_start takes priority over fill_start and cpu_req in the same cycle; those requests are dropped, not queued.
- IDLE, fill_start (no drain_start): latch fill_idx, count = 0, go to FILL. fill_start takes priority over cpu_req.
- FILL: fill_ready = 1. On fill_valid, write fill_data to {latched idx, count} and increment count. The write at count = WORDS-1 returns the FSM to IDLE with done = 1 for one cycle.
- DRAIN: drain_valid = 1 from the cycle after drain_start.
  - On drain_valid & drain_ready, the read address advances to count+1 so the next word is registered without a bubble. Otherwise the read address stays at count and drain_data holds stable.
  - drain_last = (count == WORDS-1). The handshake on the last word returns the FSM to IDLE and pulses done.
- In FILL and DRAIN: cpu_req is ignored, cpu_rvalid = 0, and fill_start / drain_start are ignored.
- Counter width is WORDS_W. It never wraps inside a burst, because the last word always exits the state.

## Timing
- CPU read latency: 1 cycle, req at edge N gives data after edge N+1.
- CPU write: committed at the next edge. A read in the following cycle returns the new data.
- Fill throughput: 1 word per cycle when fill_valid is held. Minimum burst is WORDS cycles. done is asserted in the cycle after the last accepted word.
- Drain throughput: 1 word per cycle when drain_ready is held. The first word is valid 1 cycle after drain_start. drain_valid stays high until its handshake (no retraction).
- done, busy and cpu_rvalid are registered.
- An iRST assertion mid-burst aborts immediately: the FSM returns to IDLE with no done pulse, and a partially filled block keeps the words already written.

## Structure
- A shared cache package holds the FSM state enum and the byte-enable width (DATA_W/8) helper, alongside the existing cache constants.
- One sub-module, cache_block_ram: a synchronous-read RAM with per-byte write enables, 2**(IDX_W+WORDS_W) x DATA_W, with one write port and one registered read port. The FSM, counter and muxing stay in the top module.

## Test plan
- Reset, then CPU write 0xDEADBEEF with be = 4'b1111 to idx 3 off 1, then read idx 3 off 1 -> cpu_rdata = 0xDEADBEEF, cpu_rvalid high exactly 1 cycle later.
- Byte-enable write: 0x11223344 be = 4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44.
- fill_start idx 7 with fill_valid toggling 1,0,1,1,1 and words 0xA0..0xA3 -> 4 writes, done 1 cycle after the last accepted word; CPU reads of idx 7 offs 0..3 return 0xA0..0xA3.
- drain_start idx 7 with drain_ready pattern 1,0,0,1,1,1 -> drain_data sequence 0xA0..0xA3, held stable during stalls, drain_last only on 0xA3, done then busy = 0.
- Same-cycle drain_start, fill_start and cpu_req -> DRAIN entered; no fill and no CPU write take effect.
- iRST pulsed after 2 fill words -> busy = 0 and done = 0; words 0-1 hold the new data, words 2-3 keep their old data.

Source files
------------

// File: rtl/cache_block_memory_pkg.sv
// Shared L1 cache definitions: geometry constants, the block-memory burst FSM
// state encoding and the byte-enable width helper.
package cache_block_memory_pkg;

    localparam int CACHE_DATA_W  = 32;
    localparam int CACHE_IDX_W   = 5;
    localparam int CACHE_WORDS_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/cache_block_ram.sv
// Block data storage: one byte-masked write port and one registered read port.
// The read register is resettable so the outputs it feeds come up as zero.
module cache_block_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [BE_W-1:0]   i_wbe,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge iCLK) begin
        for (int b = 0; b < BE_W; b++) begin
            if (i_wbe[b]) begin
                r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_block_memory.sv
// L1 cache data array: single-word CPU port plus block refill and write-back
// drain burst engines sharing one RAM.
module cache_block_memory
    import cache_block_memory_pkg::*;
#(
    parameter int DATA_W  = CACHE_DATA_W,
    parameter int IDX_W   = CACHE_IDX_W,
    parameter int WORDS_W = CACHE_WORDS_W
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [be_width(DATA_W)-1:0] cpu_be,
    input  logic [IDX_W-1:0]            cpu_idx,
    input  logic [WORDS_W-1:0]          cpu_off,
    input  logic [DATA_W-1:0]           cpu_wdata,
    output logic [DATA_W-1:0]           cpu_rdata,
    output logic                        cpu_rvalid,
    input  logic                        fill_start,
    input  logic [IDX_W-1:0]            fill_idx,
    input  logic                        fill_valid,
    input  logic [DATA_W-1:0]           fill_data,
    output logic                        fill_ready,
    input  logic                        drain_start,
    input  logic [IDX_W-1:0]            drain_idx,
    output logic                        drain_valid,
    output logic [DATA_W-1:0]           drain_data,
    output logic                        drain_last,
    input  logic                        drain_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int BE_W   = be_width(DATA_W);
    localparam int ADDR_W = IDX_W + WORDS_W;
    localparam logic [WORDS_W-1:0] LAST_WORD = '1;

    state_t             r_state;
    logic [WORDS_W-1:0] r_count;
    logic [IDX_W-1:0]   r_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_cpu_rvalid;
    logic               r_drain_valid;

    logic               w_idle;
    logic               w_last;
    logic               w_cpu_go;
    logic               w_drain_hs;
    logic [WORDS_W-1:0] w_next_count;
    logic [BE_W-1:0]    w_wbe;
    logic [ADDR_W-1:0]  w_waddr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_re;
    logic [ADDR_W-1:0]  w_raddr;
    logic [DATA_W-1:0]  w_rdata;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_last       = (r_count == LAST_WORD);
    assign w_cpu_go     = w_idle & cpu_req & ~drain_start & ~fill_start;
    assign w_drain_hs   = r_drain_valid & drain_ready;
    assign w_next_count = r_count + 1'b1;

    // RAM port steering: CPU owns the ports only in IDLE with no burst starting.
    always_comb begin
        w_wbe   = '0;
        w_waddr = {cpu_idx, cpu_off};
        w_wdata = cpu_wdata;
        w_re    = 1'b0;
        w_raddr = {cpu_idx, cpu_off};
        case (r_state)
            ST_IDLE: begin
                if (drain_start) begin
                    w_re    = 1'b1;
                    w_raddr = {drain_idx, {WORDS_W{1'b0}}};
                end else if (w_cpu_go) begin
                    if (cpu_we) begin
                        w_wbe = cpu_be;
                    end else begin
                        w_re = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (fill_valid) begin
                    w_wbe   = '1;
                    w_waddr = {r_idx, r_count};
                    w_wdata = fill_data;
                end
            end
            ST_DRAIN: begin
                // Prefetch the next word on a handshake so drain runs without bubbles.
                w_re    = w_drain_hs & ~w_last;
                w_raddr = {r_idx, w_next_count};
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_idx         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cpu_rvalid  <= 1'b0;
            r_drain_valid <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_cpu_rvalid <= w_cpu_go & ~cpu_we;
            case (r_state)
                ST_IDLE: begin
                    if (drain_start) begin
                        r_idx         <= drain_idx;
                        r_count       <= '0;
                        r_state       <= ST_DRAIN;
                        r_busy        <= 1'b1;
                        r_drain_valid <= 1'b1;
                    end else if (fill_start) begin
                        r_idx   <= fill_idx;
                        r_count <= '0;
                        r_state <= ST_FILL;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (fill_valid) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_count <= '0;
                        end else begin
                            r_count <= w_next_count;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_hs) begin
                        if (w_last) begin
                            r_state       <= ST_IDLE;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_drain_valid <= 1'b0;
                            r_count       <= '0;
                        end else begin
                            r_count <= w_next_count;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    cache_block_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W)
    ) u_ram (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .i_wbe   (w_wbe),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign cpu_rdata   = w_rdata;
    assign drain_data  = w_rdata;
    assign cpu_rvalid  = r_cpu_rvalid;
    assign drain_valid = r_drain_valid;
    assign drain_last  = r_drain_valid & w_last;
    assign fill_ready  = (r_state == ST_FILL);
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_cache_block_memory.sv
// Directed bench for cache_block_memory: CPU byte-masked access, refill,
// write-back drain with stalls, start priority and mid-burst reset.
module tb_cache_block_memory;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_be;
    logic [4:0]  cpu_idx;
    logic [1:0]  cpu_off;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_rvalid;
    logic        fill_start, fill_valid, fill_ready;
    logic [4:0]  fill_idx;
    logic [31:0] fill_data;
    logic        drain_start, drain_valid, drain_last, drain_ready;
    logic [4:0]  drain_idx;
    logic [31:0] drain_data;
    logic        busy, done;

    int total = 0;
    int bad   = 0;

    cache_block_memory dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_be      (cpu_be),
        .cpu_idx     (cpu_idx),
        .cpu_off     (cpu_off),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .fill_start  (fill_start),
        .fill_idx    (fill_idx),
        .fill_valid  (fill_valid),
        .fill_data   (fill_data),
        .fill_ready  (fill_ready),
        .drain_start (drain_start),
        .drain_idx   (drain_idx),
        .drain_valid (drain_valid),
        .drain_data  (drain_data),
        .drain_last  (drain_last),
        .drain_ready (drain_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cpu_idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0;
    endtask

    task automatic cpu_write(input logic [4:0] idx, input logic [1:0] off,
                             input logic [3:0] be, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = be;
        cpu_idx = idx; cpu_off = off; cpu_wdata = d;
        tick();
        cpu_idle();
    endtask

    task automatic cpu_read_chk(input string tag, input logic [4:0] idx,
                                input logic [1:0] off, input logic [31:0] exp);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_idx = idx; cpu_off = off;
        tick();
        cpu_idle();
        chk1({tag, "_rvalid"}, cpu_rvalid, 1'b1);
        chk32(tag, cpu_rdata, exp);
    endtask

    initial begin
        int k;
        logic fpat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic dpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        iRST = 1'b1;
        cpu_idle();
        cpu_idx = '0; cpu_off = '0; cpu_wdata = '0;
        fill_start = 1'b0; fill_idx = '0; fill_valid = 1'b0; fill_data = '0;
        drain_start = 1'b0; drain_idx = '0; drain_ready = 1'b0;
        tick();
        tick();
        chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk32("rst_drain_data", drain_data, 32'h0);
        chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        chk1("rst_drain_valid", drain_valid, 1'b0);
        chk1("rst_drain_last", drain_last, 1'b0);
        chk1("rst_fill_ready", fill_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        iRST = 1'b0;
        tick();

        // Full-word write then read, rvalid for exactly one cycle.
        cpu_write(5'd3, 2'd1, 4'b1111, 32'hDEADBEEF);
        chk1("wr_no_rvalid", cpu_rvalid, 1'b0);
        cpu_read_chk("rd_full", 5'd3, 2'd1, 32'hDEADBEEF);
        tick();
        chk1("rvalid_one_cycle", cpu_rvalid, 1'b0);

        // Byte-masked write, then an all-zero mask that must change nothing.
        cpu_write(5'd3, 2'd1, 4'b0101, 32'h11223344);
        cpu_read_chk("rd_be0101", 5'd3, 2'd1, 32'hDE22BE44);
        cpu_write(5'd3, 2'd1, 4'b0000, 32'hFFFFFFFF);
        cpu_read_chk("rd_be0000", 5'd3, 2'd1, 32'hDE22BE44);

        // Refill idx 7 with a gapped fill_valid pattern.
        fill_start = 1'b1; fill_idx = 5'd7;
        tick();
        fill_start = 1'b0;
        chk1("fill_busy", busy, 1'b1);
        chk1("fill_ready", fill_ready, 1'b1);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            fill_valid = fpat[i];
            fill_data  = 32'hA0 + 32'(k);
            tick();
            if (fpat[i]) k++;
            if (i < 4) chk1("fill_done_early", done, 1'b0);
        end
        fill_valid = 1'b0;
        chk1("fill_done", done, 1'b1);
        chk1("fill_busy_end", busy, 1'b0);
        chk1("fill_ready_end", fill_ready, 1'b0);
        tick();
        chk1("fill_done_pulse", done, 1'b0);
        for (int i = 0; i < 4; i++)
            cpu_read_chk("rd_fill", 5'd7, 2'(i), 32'hA0 + 32'(i));

        // Drain idx 7 with stalls on drain_ready.
        drain_start = 1'b1; drain_idx = 5'd7;
        tick();
        drain_start = 1'b0;
        chk1("drain_busy", busy, 1'b1);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            chk1("drain_valid", drain_valid, 1'b1);
            chk32("drain_data", drain_data, 32'hA0 + 32'(k));
            chk1("drain_last", drain_last, (k == 3));
            drain_ready = dpat[i];
            tick();
            if (dpat[i]) k++;
        end
        drain_ready = 1'b0;
        chk1("drain_done", done, 1'b1);
        chk1("drain_busy_end", busy, 1'b0);
        chk1("drain_valid_end", drain_valid, 1'b0);
        tick();
        chk1("drain_done_pulse", done, 1'b0);

        // Simultaneous starts and CPU write: drain wins, others dropped.
        drain_start = 1'b1; drain_idx = 5'd7;
        fill_start = 1'b1; fill_idx = 5'd3;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF;
        cpu_idx = 5'd3; cpu_off = 2'd1; cpu_wdata = 32'h12345678;
        tick();
        drain_start = 1'b0; fill_start = 1'b0;
        cpu_wdata = 32'h55555555;
        chk1("prio_fill_ready", fill_ready, 1'b0);
        drain_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk1("prio_drain_valid", drain_valid, 1'b1);
            chk32("prio_drain_data", drain_data, 32'hA0 + 32'(i));
            tick();
            chk1("prio_cpu_rvalid", cpu_rvalid, 1'b0);
        end
        drain_ready = 1'b0;
        cpu_idle();
        chk1("prio_done", done, 1'b1);
        tick();
        cpu_read_chk("rd_prio", 5'd3, 2'd1, 32'hDE22BE44);

        // Reset in the middle of a refill.
        fill_start = 1'b1; fill_idx = 5'd7;
        tick();
        fill_start = 1'b0;
        fill_valid = 1'b1; fill_data = 32'hB0;
        tick();
        fill_data = 32'hB1;
        tick();
        fill_valid = 1'b0;
        iRST = 1'b1;
        #2;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk1("abort_fill_ready", fill_ready, 1'b0);
        tick();
        iRST = 1'b0;
        tick();
        chk1("abort_done_after", done, 1'b0);
        cpu_read_chk("rd_abort0", 5'd7, 2'd0, 32'hB0);
        cpu_read_chk("rd_abort1", 5'd7, 2'd1, 32'hB1);
        cpu_read_chk("rd_abort2", 5'd7, 2'd2, 32'hA2);
        cpu_read_chk("rd_abort3", 5'd7, 2'd3, 32'hA3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
